// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search scheduler and the SAD engine it drives.
package sad_pkg;

  // Default widths for the B-memory address, SAD result and candidate index.
  localparam int ADDR_W_DEF = 15;
  localparam int SAD_W_DEF  = 32;
  localparam int IDX_W_DEF  = 7;

  // Largest representable SAD; the "nothing found yet" value of the tracker.
  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  // Engine handshake levels: Go and Done are both single-cycle, active-high
  // pulses, and the engine result is only meaningful while Done is high.
  localparam logic ENG_GO_ON   = 1'b1;
  localparam logic ENG_GO_OFF  = 1'b0;
  localparam logic ENG_DONE_ON = 1'b1;

  // Scheduler states, 2-bit encoding shared with anything that decodes it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } search_state_t;

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of SAD results with the index of the first minimum seen.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clear,
  input  logic             Valid,
  input  logic [SAD_W-1:0] Sad,
  input  logic [IDX_W-1:0] Idx,
  output logic [SAD_W-1:0] Best_Sad,
  output logic [IDX_W-1:0] Best_Idx
);

  logic [SAD_W-1:0] best_sad_reg;
  logic [IDX_W-1:0] best_idx_reg;

  // Strict less-than keeps the earlier index on ties; Clear restarts at SAD_MAX.
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      best_sad_reg <= '1;
      best_idx_reg <= '0;
    end else if (Valid && (Sad < best_sad_reg)) begin
      best_sad_reg <= Sad;
      best_idx_reg <= Idx;
    end
  end

  assign Best_Sad = best_sad_reg;
  assign Best_Idx = best_idx_reg;

endmodule

// File: rtl/sad_search_ctrl.sv
// Search scheduler: launches the SAD engine once per candidate block, walks
// the candidate addresses and reports the best match with a Done pulse.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SAD_W  = SAD_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic [IDX_W-1:0]  Num_Cand,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W-1:0] Stride,
  output logic              Eng_Go,
  output logic [ADDR_W-1:0] Eng_B_Base,
  input  logic              Eng_Done,
  input  logic [SAD_W-1:0]  Eng_Sad,
  output logic              Busy,
  output logic              Done,
  output logic [SAD_W-1:0]  Best_Sad,
  output logic [IDX_W-1:0]  Best_Idx
);

  search_state_t     state_reg;
  logic [IDX_W-1:0]  num_cand_reg;
  logic [IDX_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  cnt_next;
  logic [ADDR_W-1:0] stride_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [ADDR_W-1:0] eng_b_base_reg;
  logic              eng_go_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              start_accept;
  logic              result_accept;

  // Cnt only reaches Num_Cand-1 before the search ends, so +1 never wraps.
  assign cnt_next = cnt_reg + IDX_W'(1);

  // A new search clears the tracker; a result counts only in WAIT and only
  // when no Abort arrives in the same cycle.
  assign start_accept  = (state_reg == ST_IDLE) && Start;
  assign result_accept = (state_reg == ST_WAIT) && (Eng_Done == ENG_DONE_ON) && !Abort;

  // Scheduler FSM with counters, address generator and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= ST_IDLE;
      num_cand_reg   <= '0;
      stride_reg     <= '0;
      cur_addr_reg   <= '0;
      cnt_reg        <= '0;
      eng_go_reg     <= ENG_GO_OFF;
      eng_b_base_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else if (Abort && (state_reg != ST_IDLE)) begin
      // Abort drops straight back to IDLE; partial best results are kept.
      state_reg  <= ST_IDLE;
      eng_go_reg <= ENG_GO_OFF;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (Start) begin
            num_cand_reg <= Num_Cand;
            stride_reg   <= Stride;
            cur_addr_reg <= Base_Addr;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= (Num_Cand == '0) ? ST_FINISH : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          eng_go_reg     <= ENG_GO_ON;
          eng_b_base_reg <= cur_addr_reg;
          state_reg      <= ST_WAIT;
        end
        ST_WAIT: begin
          eng_go_reg <= ENG_GO_OFF;
          if (Eng_Done == ENG_DONE_ON) begin
            cnt_reg      <= cnt_next;
            // Address arithmetic is modulo 2^ADDR_W by construction.
            cur_addr_reg <= cur_addr_reg + stride_reg;
            state_reg    <= (cnt_next == num_cand_reg) ? ST_FINISH : ST_LAUNCH;
          end
        end
        ST_FINISH: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  sad_min_tracker #(
    .SAD_W (SAD_W),
    .IDX_W (IDX_W)
  ) u_min_tracker (
    .Clk      (Clk),
    .Rst      (Rst),
    .Clear    (start_accept),
    .Valid    (result_accept),
    .Sad      (Eng_Sad),
    .Idx      (cnt_reg),
    .Best_Sad (Best_Sad),
    .Best_Idx (Best_Idx)
  );

  assign Eng_Go     = eng_go_reg;
  assign Eng_B_Base = eng_b_base_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Search scheduler for the SAD engine: sequences the engine over a list of `Num_Cand` candidate blocks spaced `Stride` apart in B memory. It launches one SAD computation per candidate and tracks the minimum SAD and its index. It reports the best match with a one-cycle `Done` pulse. It sits between the motion-search top level and a single SAD engine, and is the only block that drives the engine's `Go`.

## Interface
- `ADDR_W`, 15, B-memory address width
- `SAD_W`, 32, SAD result width
- `IDX_W`, 7, candidate index/count width

Ports:
- `Clk`  in  1  clock; all logic on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Start`  in  1  begin search; sampled only in IDLE
- `Abort`  in  1  cancel search; sampled in any non-IDLE state
- `Num_Cand`  in  IDX_W  number of candidates; latched on Start
- `Base_Addr`  in  ADDR_W  B base address of candidate 0; latched on Start
- `Stride`  in  ADDR_W  address step between candidates; latched on Start
- `Eng_Go`  out  1  one-cycle launch pulse to the SAD engine
- `Eng_B_Base`  out  ADDR_W  current candidate base; stable from launch until Eng_Done
- `Eng_Done`  in  1  engine completion pulse
- `Eng_Sad`  in  SAD_W  engine result; valid when Eng_Done=1
- `Busy`  out  1  high from the cycle after accepted Start until Done/abort
- `Done`  out  1  one-cycle pulse; search complete
- `Best_Sad`  out  SAD_W  minimum SAD so far
- `Best_Idx`  out  IDX_W  index of the minimum

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH. Encoding is 2 bits, shared.
- All outputs are registered. Reset values: State=IDLE, all outputs 0, except `Best_Sad`=all ones (SAD_MAX).
- IDLE, Start=1:
  - latch Num_Cand, Stride; Cur_Addr←Base_Addr; Cnt←0; Best_Sad←SAD_MAX; Best_Idx←0; Busy←1.
  - Next state is LAUNCH, or FINISH if Num_Cand=0.
- LAUNCH: `Eng_Go`←1; `Eng_B_Base`←Cur_Addr; go to WAIT.
- WAIT:
  - `Eng_Go`←0.
  - On Eng_Done=1 with Eng_Sad < Best_Sad (strict unsigned): Best_Sad←Eng_Sad, Best_Idx←Cnt. Ties keep the earlier index.
  - Also on Eng_Done: Cnt←Cnt+1; Cur_Addr←Cur_Addr+Stride, mod 2^ADDR_W (wraps silently).
  - Then go to FINISH if Cnt+1=Num_Cand, else LAUNCH.
- FINISH: Done←1 (one cycle); Busy←0; go to IDLE.
- Eng_Done outside WAIT is ignored.
- Start while not IDLE is ignored; latched parameters do not change mid-search.
- Abort in LAUNCH/WAIT/FINISH: next edge → IDLE, Busy←0, Eng_Go←0, no Done pulse. Best_Sad/Best_Idx keep their partial values.
- Abort has priority over Eng_Done in the same cycle.
- Rst has priority over everything. Rst mid-search returns to the reset values; the engine is not signalled.
- Num_Cand=2^IDX_W−1 is the maximum. Cnt never wraps.

## Timing
- Start sampled at edge k:
  - Busy=1 in cycle k+1.
  - Eng_Go=1 in cycle k+2, for exactly one cycle.
- Eng_Done sampled at edge m:
  - Best_Sad/Best_Idx updated in cycle m+1.
  - Next Eng_Go in cycle m+2, or Done=1 with Busy=0 in cycle m+2 for the last candidate.
- Num_Cand=0: Done in cycle k+2, Best_Sad=SAD_MAX, Best_Idx=0.
- Per-candidate overhead beyond engine latency: 2 cycles.
- Best_Sad/Best_Idx hold after Done until the next accepted Start.

## Structure
- Shared package `sad_pkg` holds:
  - state typedef/encoding (IDLE, LAUNCH, WAIT, FINISH)
  - ADDR_W/SAD_W/IDX_W defaults
  - SAD_MAX constant
  - the engine handshake constants shared with the SAD engine
- One sub-module, `sad_min_tracker`: holds Best_Sad/Best_Idx.
  - Inputs: clear, valid, sad, idx.
  - Does the strict-less-than compare and update.
- The FSM, counters and address generator stay in the top.

## Test plan
- Num_Cand=3, Base=0x0100, Stride=0x0040; engine returns 50, 20, 20:
  - Eng_B_Base = 0x0100, 0x0140, 0x0180.
  - Best_Sad=20, Best_Idx=1; one Done pulse; Busy falls with Done.
- Num_Cand=0, Start → Done 2 cycles after Start with Best_Sad=0xFFFFFFFF, Best_Idx=0, and no Eng_Go.
- Base=0x7FF0, Stride=0x0020, Num_Cand=2 → second Eng_B_Base=0x0010 (wrap).
- Num_Cand=4, Abort during the second WAIT:
  - IDLE next cycle, no Done, Best_Idx=0 (first result kept).
  - A new Start then runs cleanly.
- Start pulsed again during WAIT, plus a stray Eng_Done in LAUNCH → both ignored; candidate count and addresses unchanged.
- Rst asserted in WAIT → every output returns to its reset value next cycle. A later Eng_Done is ignored.
